// File: rtl/multicycle_control_unit_if.sv
// Data-memory bus between the multi-cycle control unit (master) and data memory (slave).
interface multicycle_control_unit_if #(
  parameter int XLEN = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32I multi-cycle control unit: IDLE -> EXEC -> (MEM) -> WB | TRAP, all outputs registered.
module multicycle_control_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_valid,
  input  logic [6:0]                 opcode,
  input  logic [2:0]                 funct3,
  input  logic [4:0]                 rd,
  input  logic [XLEN-1:0]            rs1_val,
  input  logic [XLEN-1:0]            rs2_val,
  input  logic [XLEN-1:0]            imm,
  input  logic [XLEN-1:0]            pc,
  input  logic [XLEN-1:0]            alu_result,
  multicycle_control_unit_if.master  mem_if,
  output logic                       instr_ready,
  output logic                       alu_en,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       pc_we,
  output logic [XLEN-1:0]            pc_next,
  output logic                       trap,
  output logic [1:0]                 trap_cause
);
  localparam int LANES = XLEN / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t            state_r;
  logic [6:0]        op_r;
  logic [2:0]        f3_r;
  logic [4:0]        rd_r;
  logic [XLEN-1:0]   rs1_r, rs2_r, imm_r, pc_r;
  logic [XLEN-1:0]   wbv_r, pcn_r;
  logic [CW-1:0]     cnt_r;

  logic [XLEN-1:0]   raw_addr_s, addr_s, pc4_s, pcimm_s, pcn_s, wbv_s;
  logic [XLEN-1:0]   wdata_s, shifted_s, load_s;
  logic [LANES-1:0]  be_s;
  logic [LW-1:0]     lane_s;
  logic [2:0]        nbytes_s;
  logic              misalign_s, illegal_s, is_mem_s, is_alu_s, writes_rd_s;
  logic              taken_s, alu_in_s;

  // Address generation, store lanes, load extraction, branch resolution and decode checks.
  always_comb begin
    raw_addr_s = rs1_r + imm_r;
    addr_s     = raw_addr_s;
    misalign_s = 1'b0;
    nbytes_s   = 3'd4;
    case (f3_r[1:0])
      2'b00:   nbytes_s = 3'd1;
      2'b01:   begin nbytes_s = 3'd2; misalign_s = raw_addr_s[0]; addr_s[0] = 1'b0; end
      default: begin nbytes_s = 3'd4; misalign_s = |raw_addr_s[1:0]; addr_s[1:0] = 2'b00; end
    endcase
    lane_s  = addr_s[LW-1:0];
    be_s    = {LANES{1'b0}};
    wdata_s = ZERO;
    for (int i = 0; i < LANES; i++) begin
      be_s[i] = (i >= int'(lane_s)) && (i < (int'(lane_s) + int'(nbytes_s)));
      wdata_s[8*i +: 8] = rs2_r[8*(i % int'(nbytes_s)) +: 8];
    end

    // Memory returns the full bus word; the lane shift brings the addressed datum to bit 0.
    shifted_s = mem_if.mem_rdata >> {lane_s, 3'b000};
    case (f3_r)
      3'b000:  load_s = XLEN'($signed(shifted_s[7:0]));
      3'b001:  load_s = XLEN'($signed(shifted_s[15:0]));
      3'b010:  load_s = XLEN'($signed(shifted_s[31:0]));
      3'b100:  load_s = XLEN'(shifted_s[7:0]);
      3'b101:  load_s = XLEN'(shifted_s[15:0]);
      default: load_s = shifted_s;
    endcase

    case (f3_r)
      3'b000:  taken_s = (rs1_r == rs2_r);
      3'b001:  taken_s = (rs1_r != rs2_r);
      3'b100:  taken_s = ($signed(rs1_r) < $signed(rs2_r));
      3'b101:  taken_s = !($signed(rs1_r) < $signed(rs2_r));
      3'b110:  taken_s = (rs1_r < rs2_r);
      3'b111:  taken_s = !(rs1_r < rs2_r);
      default: taken_s = 1'b0;
    endcase

    pc4_s       = pc_r + XLEN'(4);
    pcimm_s     = pc_r + imm_r;
    pcn_s       = pc4_s;
    wbv_s       = ZERO;
    illegal_s   = 1'b0;
    is_mem_s    = 1'b0;
    is_alu_s    = 1'b0;
    writes_rd_s = 1'b1;
    // Reserved funct3 encodings of load/store/branch are treated like unknown opcodes.
    case (op_r)
      OP_REG, OP_IMM: is_alu_s = 1'b1;
      OP_LUI:    wbv_s = imm_r;
      OP_AUIPC:  wbv_s = pcimm_s;
      OP_JAL:    begin wbv_s = pc4_s; pcn_s = pcimm_s; end
      OP_JALR:   begin wbv_s = pc4_s; pcn_s = {raw_addr_s[XLEN-1:1], 1'b0}; end
      OP_BRANCH: begin
        writes_rd_s = 1'b0;
        pcn_s       = taken_s ? pcimm_s : pc4_s;
        illegal_s   = (f3_r[2:1] == 2'b01);
      end
      OP_LOAD:   begin
        is_mem_s  = 1'b1;
        illegal_s = (f3_r == 3'b011) || (f3_r[2:1] == 2'b11);
      end
      OP_STORE:  begin
        is_mem_s    = 1'b1;
        writes_rd_s = 1'b0;
        illegal_s   = f3_r[2] || (f3_r[1:0] == 2'b11);
      end
      default:   begin illegal_s = 1'b1; writes_rd_s = 1'b0; end
    endcase

    alu_in_s = (opcode == OP_REG) || (opcode == OP_IMM);
  end

  // Sequencer: state, latched instruction, timeout counter and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= S_IDLE;
      op_r             <= 7'd0;
      f3_r             <= 3'd0;
      rd_r             <= 5'd0;
      rs1_r            <= ZERO;
      rs2_r            <= ZERO;
      imm_r            <= ZERO;
      pc_r             <= ZERO;
      wbv_r            <= ZERO;
      pcn_r            <= ZERO;
      cnt_r            <= {CW{1'b0}};
      instr_ready      <= 1'b1;
      alu_en           <= 1'b0;
      mem_if.mem_req   <= 1'b0;
      mem_if.mem_we    <= 1'b0;
      mem_if.mem_addr  <= ZERO;
      mem_if.mem_wdata <= ZERO;
      mem_if.mem_be    <= {LANES{1'b0}};
      rf_we            <= 1'b0;
      rf_waddr         <= 5'd0;
      rf_wdata         <= ZERO;
      pc_we            <= 1'b0;
      pc_next          <= ZERO;
      trap             <= 1'b0;
      trap_cause       <= 2'd0;
    end else begin
      alu_en <= 1'b0;
      rf_we  <= 1'b0;
      pc_we  <= 1'b0;
      trap   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (instr_valid) begin
            op_r        <= opcode;
            f3_r        <= funct3;
            rd_r        <= rd;
            rs1_r       <= rs1_val;
            rs2_r       <= rs2_val;
            imm_r       <= imm;
            pc_r        <= pc;
            alu_en      <= alu_in_s;
            instr_ready <= 1'b0;
            state_r     <= S_EXEC;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_EXEC: begin
          wbv_r <= wbv_s;
          pcn_r <= pcn_s;
          if (illegal_s) begin
            trap       <= 1'b1;
            trap_cause <= 2'd0;
            state_r    <= S_TRAP;
          end else if (is_mem_s && misalign_s && TRAP_EN) begin
            trap       <= 1'b1;
            trap_cause <= 2'd1;
            state_r    <= S_TRAP;
          end else if (is_mem_s) begin
            mem_if.mem_req   <= 1'b1;
            mem_if.mem_we    <= (op_r == OP_STORE);
            mem_if.mem_addr  <= addr_s;
            mem_if.mem_wdata <= wdata_s;
            mem_if.mem_be    <= be_s;
            cnt_r            <= {CW{1'b0}};
            state_r          <= S_MEM;
          end else begin
            state_r <= S_WB;
          end
        end
        S_MEM: begin
          // A response in the final allowed cycle still completes the access.
          if (mem_if.mem_ready) begin
            mem_if.mem_req <= 1'b0;
            mem_if.mem_we  <= 1'b0;
            mem_if.mem_be  <= {LANES{1'b0}};
            wbv_r          <= load_s;
            state_r        <= S_WB;
          end else if (cnt_r == CW'(MEM_TIMEOUT)) begin
            mem_if.mem_req <= 1'b0;
            mem_if.mem_we  <= 1'b0;
            mem_if.mem_be  <= {LANES{1'b0}};
            trap           <= 1'b1;
            trap_cause     <= 2'd2;
            state_r        <= S_TRAP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_WB: begin
          pc_we       <= 1'b1;
          pc_next     <= pcn_r;
          rf_we       <= writes_rd_s && (rd_r != 5'd0);
          rf_waddr    <= rd_r;
          rf_wdata    <= is_alu_s ? alu_result : wbv_r;
          instr_ready <= 1'b1;
          state_r     <= S_IDLE;
        end
        S_TRAP: begin
          instr_ready <= 1'b1;
          state_r     <= S_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: table of non-memory instructions plus hand-written load/store/trap/reset sequences.
module tb_multicycle_control_unit;
  localparam int MT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] rs1_val = 32'd0, rs2_val = 32'd0, imm = 32'd0, pc = 32'd0, alu_result = 32'd0;
  logic        instr_ready, alu_en, rf_we, pc_we, trap;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pc_next;
  logic [1:0]  trap_cause;

  multicycle_control_unit_if #(.XLEN(32)) mb ();

  multicycle_control_unit #(.XLEN(32), .MEM_TIMEOUT(MT), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct3(funct3),
    .rd(rd), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .alu_result(alu_result), .mem_if(mb.master), .instr_ready(instr_ready),
    .alu_en(alu_en), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_we(pc_we), .pc_next(pc_next), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2, imm, pc, alu;
    logic        exp_alu_en, exp_trap;
    logic [1:0]  exp_cause;
    logic        exp_rf_we;
    logic [31:0] exp_wdata, exp_pcn;
  } vec_t;

  typedef struct {
    logic        done, alu_en_exec, ready_exec, unstable, we, trap, rf_we, pc_we;
    int          lat, rf_we_cnt, req_cycles;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rf_wdata, pc_next;
    logic [1:0]  cause;
    logic [4:0]  waddr;
  } res_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rdi, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] im, input logic [31:0] p, input logic [31:0] al,
                              input logic ea, input logic et, input logic [1:0] ec,
                              input logic ew, input logic [31:0] wd, input logic [31:0] pn);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.rd = rdi; v.rs1 = a; v.rs2 = b; v.imm = im;
    v.pc = p; v.alu = al; v.exp_alu_en = ea; v.exp_trap = et; v.exp_cause = ec;
    v.exp_rf_we = ew; v.exp_wdata = wd; v.exp_pcn = pn;
    return v;
  endfunction

  // Issue one instruction, play the memory side, and record everything up to the WB/TRAP pulse.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdi,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                           input logic [31:0] p, input logic [31:0] al, input logic [31:0] rdata,
                           input int ready_wait, input logic hold, output res_t r);
    r.done = 1'b0; r.alu_en_exec = 1'b0; r.ready_exec = 1'b0; r.unstable = 1'b0; r.we = 1'b0;
    r.trap = 1'b0; r.rf_we = 1'b0; r.pc_we = 1'b0; r.lat = -1; r.rf_we_cnt = 0; r.req_cycles = 0;
    r.be = 4'h0; r.addr = 32'h0; r.wdata = 32'h0; r.rf_wdata = 32'h0; r.pc_next = 32'h0;
    r.cause = 2'd0; r.waddr = 5'd0;
    @(negedge clk);
    opcode = op; funct3 = f3; rd = rdi; rs1_val = a; rs2_val = b; imm = im; pc = p;
    alu_result = al; mb.mem_rdata = rdata; mb.mem_ready = 1'b0; instr_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        r.alu_en_exec = alu_en;
        r.ready_exec  = instr_ready;
        if (hold) opcode = 7'h7F;
        else instr_valid = 1'b0;
      end else begin
        instr_valid = 1'b0;
      end
      if (rf_we) r.rf_we_cnt++;
      mb.mem_ready = 1'b0;
      if (mb.mem_req) begin
        r.req_cycles++;
        if (r.req_cycles == 1) begin
          r.be = mb.mem_be; r.addr = mb.mem_addr; r.wdata = mb.mem_wdata; r.we = mb.mem_we;
        end else if (mb.mem_be !== r.be || mb.mem_addr !== r.addr ||
                     mb.mem_wdata !== r.wdata || mb.mem_we !== r.we) begin
          r.unstable = 1'b1;
        end
        if (ready_wait >= 0 && r.req_cycles == ready_wait + 1) mb.mem_ready = 1'b1;
      end
      if (pc_we || trap) begin
        r.done = 1'b1; r.lat = k - 1; r.trap = trap; r.cause = trap_cause;
        r.rf_we = rf_we; r.pc_we = pc_we; r.waddr = rf_waddr; r.rf_wdata = rf_wdata;
        r.pc_next = pc_next;
        break;
      end
    end
    mb.mem_ready = 1'b0;
    instr_valid  = 1'b0;
    if (!r.done) begin
      checks++; failures++;
      $display("FAIL timeout: no WB/TRAP pulse within 40 cycles (op 0x%02h)", op);
    end
  endtask

  res_t r;
  logic seen;

  initial begin
    mb.mem_ready = 1'b0;
    mb.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_zero_outs", {alu_en, mb.mem_req, mb.mem_we, mb.mem_be, rf_we, pc_we, trap, trap_cause}, 0);
    chk("rst_data_outs", mb.mem_addr | mb.mem_wdata | rf_wdata | pc_next, 0);
    rst = 1'b0;

    vq.push_back(mk("addi_x5",   7'h13, 3'd0, 5'd5, 32'd2, 32'd0, 32'd5, 32'h40, 32'h7,
                    1'b1, 1'b0, 2'd0, 1'b1, 32'h7, 32'h44));
    vq.push_back(mk("add_x0",    7'h33, 3'd0, 5'd0, 32'd1, 32'd2, 32'd0, 32'h100, 32'h1234,
                    1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h104));
    vq.push_back(mk("lui",       7'h37, 3'd0, 5'd3, 32'd0, 32'd0, 32'h12345000, 32'h200, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b1, 32'h12345000, 32'h204));
    vq.push_back(mk("auipc",     7'h17, 3'd0, 5'd4, 32'd0, 32'd0, 32'h1000, 32'h200, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b1, 32'h1200, 32'h204));
    vq.push_back(mk("jal",       7'h6F, 3'd0, 5'd1, 32'd0, 32'd0, 32'h20, 32'h300, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b1, 32'h304, 32'h320));
    vq.push_back(mk("jalr",      7'h67, 3'd0, 5'd1, 32'h1001, 32'd0, 32'd4, 32'h300, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b1, 32'h304, 32'h1004));
    vq.push_back(mk("blt_taken", 7'h63, 3'd4, 5'd0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF8, 32'h40, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h38));
    vq.push_back(mk("bltu_nt",   7'h63, 3'd6, 5'd0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF8, 32'h40, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h44));
    vq.push_back(mk("beq_taken", 7'h63, 3'd0, 5'd0, 32'd5, 32'd5, 32'h10, 32'h40, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h50));
    vq.push_back(mk("bne_nt",    7'h63, 3'd1, 5'd0, 32'd5, 32'd5, 32'h10, 32'h40, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h44));
    vq.push_back(mk("bge_taken", 7'h63, 3'd5, 5'd0, 32'd1, 32'hFFFFFFFF, 32'h10, 32'h80, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h90));
    vq.push_back(mk("bgeu_nt",   7'h63, 3'd7, 5'd0, 32'd1, 32'hFFFFFFFF, 32'h10, 32'h80, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h84));
    vq.push_back(mk("illegal",   7'h7F, 3'd0, 5'd2, 32'd0, 32'd0, 32'd0, 32'h40, 32'h0,
                    1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0));
    vq.push_back(mk("auipc_wrap", 7'h17, 3'd0, 5'd7, 32'd0, 32'd0, 32'h20, 32'hFFFFFFF0, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b1, 32'h10, 32'hFFFFFFF4));
    vq.push_back(mk("jal_wrap",  7'h6F, 3'd0, 5'd1, 32'd0, 32'd0, 32'd8, 32'hFFFFFFFC, 32'h0,
                    1'b0, 1'b0, 2'd0, 1'b1, 32'h0, 32'h4));

    foreach (vq[i]) begin
      run_instr(vq[i].op, vq[i].f3, vq[i].rd, vq[i].rs1, vq[i].rs2, vq[i].imm, vq[i].pc,
                vq[i].alu, 32'h0, -1, 1'b0, r);
      chk({vq[i].name, "_alu_en"}, r.alu_en_exec, vq[i].exp_alu_en);
      chk({vq[i].name, "_busy"}, r.ready_exec, 0);
      chk({vq[i].name, "_lat"}, r.lat, vq[i].exp_trap ? 1 : 2);
      chk({vq[i].name, "_no_mem"}, r.req_cycles, 0);
      chk({vq[i].name, "_trap"}, r.trap, vq[i].exp_trap);
      if (vq[i].exp_trap) begin
        chk({vq[i].name, "_cause"}, r.cause, vq[i].exp_cause);
        chk({vq[i].name, "_quiet"}, {r.pc_we, r.rf_we_cnt[0]}, 0);
      end else begin
        chk({vq[i].name, "_pc_we"}, r.pc_we, 1);
        chk({vq[i].name, "_pc_next"}, r.pc_next, vq[i].exp_pcn);
        chk({vq[i].name, "_rf_we"}, r.rf_we, vq[i].exp_rf_we);
        if (vq[i].exp_rf_we) begin
          chk({vq[i].name, "_waddr"}, r.waddr, vq[i].rd);
          chk({vq[i].name, "_wdata"}, r.rf_wdata, vq[i].exp_wdata);
        end
      end
    end

    // instr_valid held into EXEC with a changed opcode must not disturb the latched ADDI
    run_instr(7'h13, 3'd0, 5'd5, 32'd2, 32'd0, 32'd5, 32'h40, 32'h7, 32'h0, -1, 1'b1, r);
    chk("hold_lat", r.lat, 2);
    chk("hold_wdata", {r.trap, r.rf_we, r.rf_wdata}, {1'b0, 1'b1, 32'h7});

    run_instr(7'h03, 3'd0, 5'd9, 32'h100, 32'd0, 32'd3, 32'h40, 32'h0, 32'h80FF0000, 2, 1'b0, r);
    chk("lb_addr", r.addr, 32'h103);
    chk("lb_we", r.we, 0);
    chk("lb_req_cycles", r.req_cycles, 3);
    chk("lb_lat", r.lat, 5);
    chk("lb_stable", r.unstable, 0);
    chk("lb_wdata", r.rf_wdata, 32'hFFFFFF80);
    chk("lb_wb", {r.rf_we, r.waddr, r.pc_we, r.pc_next}, {1'b1, 5'd9, 1'b1, 32'h44});

    run_instr(7'h03, 3'd4, 5'd9, 32'h100, 32'd0, 32'd3, 32'h40, 32'h0, 32'h80FF0000, 2, 1'b0, r);
    chk("lbu_wdata", r.rf_wdata, 32'h00000080);

    run_instr(7'h03, 3'd1, 5'd10, 32'h100, 32'd0, 32'd2, 32'h40, 32'h0, 32'h80FF0000, 0, 1'b0, r);
    chk("lh_wdata", r.rf_wdata, 32'hFFFF80FF);
    chk("lh_lat", r.lat, 3);

    run_instr(7'h03, 3'd5, 5'd10, 32'h100, 32'd0, 32'd2, 32'h40, 32'h0, 32'h80FF0000, 0, 1'b0, r);
    chk("lhu_wdata", r.rf_wdata, 32'h000080FF);

    run_instr(7'h23, 3'd1, 5'd0, 32'h100, 32'h1234ABCD, 32'd2, 32'h40, 32'h0, 32'h0, 0, 1'b0, r);
    chk("sh_be", r.be, 4'hC);
    chk("sh_wdata", r.wdata, 32'hABCDABCD);
    chk("sh_we_addr", {r.we, r.addr}, {1'b1, 32'h102});
    chk("sh_no_rf_we", r.rf_we_cnt, 0);
    chk("sh_pc", {r.pc_we, r.pc_next, r.lat[3:0]}, {1'b1, 32'h44, 4'd3});

    run_instr(7'h23, 3'd0, 5'd0, 32'h100, 32'h000000EF, 32'd1, 32'h40, 32'h0, 32'h0, 1, 1'b0, r);
    chk("sb_be", r.be, 4'h2);
    chk("sb_wdata", r.wdata, 32'hEFEFEFEF);

    run_instr(7'h23, 3'd2, 5'd0, 32'h100, 32'hCAFEF00D, 32'd0, 32'h40, 32'h0, 32'h0, 0, 1'b0, r);
    chk("sw_be_wdata", {r.be, r.wdata}, {4'hF, 32'hCAFEF00D});

    run_instr(7'h03, 3'd2, 5'd6, 32'h100, 32'd0, 32'd2, 32'h40, 32'h0, 32'h0, 0, 1'b0, r);
    chk("lw_mis_trap", {r.trap, r.cause}, {1'b1, 2'd1});
    chk("lw_mis_no_req", r.req_cycles, 0);
    chk("lw_mis_lat", r.lat, 1);

    run_instr(7'h23, 3'd1, 5'd0, 32'h100, 32'd0, 32'd1, 32'h40, 32'h0, 32'h0, 0, 1'b0, r);
    chk("sh_mis_trap", {r.trap, r.cause, r.req_cycles[7:0]}, {1'b1, 2'd1, 8'd0});

    run_instr(7'h03, 3'd2, 5'd6, 32'h100, 32'd0, 32'd4, 32'h40, 32'h0, 32'h0, -1, 1'b0, r);
    chk("tmo_trap", {r.trap, r.cause}, {1'b1, 2'd2});
    chk("tmo_req_cycles", r.req_cycles, MT + 1);
    chk("tmo_lat", r.lat, MT + 2);
    chk("tmo_no_wb", {r.pc_we, r.rf_we}, 0);

    run_instr(7'h03, 3'd2, 5'd6, 32'h100, 32'd0, 32'd4, 32'h40, 32'h0, 32'hDEADBEEF, MT, 1'b0, r);
    chk("edge_ready_trap", r.trap, 0);
    chk("edge_ready_lat", r.lat, MT + 3);
    chk("edge_ready_wdata", r.rf_wdata, 32'hDEADBEEF);

    // Reset in the middle of a memory access
    @(negedge clk);
    opcode = 7'h03; funct3 = 3'd2; rd = 5'd8; rs1_val = 32'h200; imm = 32'd0; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_mem_req", mb.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", mb.mem_req, 0);
    chk("rst_ready", instr_ready, 1);
    rst = 1'b0;
    mb.mem_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mb.mem_ready = 1'b0;
      if (rf_we || pc_we || mb.mem_req) seen = 1'b1;
    end
    chk("late_ready_quiet", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
